// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - sequential RV M-extension multiply/divide unit, one bit per cycle
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;

    logic                s1, s2, sign1, sign2, div_zero, div_ovf;
    logic [XLEN-1:0]     a_mag, b_mag, special_res;
    logic [XLEN:0]       mul_sum, div_tmp, div_sub;
    logic [2*XLEN-1:0]   acc_step, prod;
    logic [XLEN-1:0]     quo, rem, final_res;

    // Operand preparation for the request currently on the inputs
    always_comb begin
        s1       = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        s2       = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sign1    = s1 & reg1[XLEN-1];
        sign2    = s2 & reg2[XLEN-1];
        a_mag    = sign1 ? -reg1 : reg1;
        b_mag    = sign2 ? -reg2 : reg2;
        div_zero = op[2] && (reg2 == '0);
        div_ovf  = op[2] && !op[0] && (reg1 == {1'b1, {(XLEN-1){1'b0}}}) && (reg2 == '1);
        if (div_zero) begin
            special_res = op[1] ? reg1 : '1;
        end else begin
            special_res = op[1] ? '0 : reg1;
        end
    end

    // One iteration: acc holds {partial high, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_tmp = acc_q[2*XLEN-1:XLEN-1];
        div_sub = div_tmp - {1'b0, b_q};
        if (op_q[2]) begin
            if (!div_sub[XLEN]) begin
                acc_step = {div_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step = {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod = neg_q ? -acc_step : acc_step;
        quo  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem  = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            final_res = op_q[1] ? rem : quo;
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        b_d      = b_q;
        result_d = result_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = op;
                    b_d    = b_mag;
                    acc_d  = {{XLEN{1'b0}}, a_mag};
                    neg_d  = sign1 ^ sign2;
                    rneg_d = sign1;
                    cnt_d  = CW'(XLEN);
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = final_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq (XLEN=32 and XLEN=8 instances)
module tb_mdu_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] reg1, reg2, result;

    logic        in_valid8, in_ready8, out_valid8;
    logic [2:0]  op8;
    logic [7:0]  reg1_8, reg2_8, result8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .reg1(reg1), .reg2(reg2), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    mdu_seq #(.XLEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .reg1(reg1_8), .reg2(reg2_8), .out_valid(out_valid8), .out_ready(1'b1), .result(result8)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 32'd0) || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // RISC-V M-extension semantics written with plain wide arithmetic
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y, p;
        int sa, sb;
        sa = a;
        sb = b;
        case (o)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
            3'd2: begin x = {{32{a[31]}}, a}; y = {32'd0, b}; p = x * y; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called at a negedge in IDLE; returns at the negedge right after the accept edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o;
        reg1 = a;
        reg2 = b;
        in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom);
        reg1 = $urandom;
        reg2 = $urandom;
    endtask

    task automatic wait_result(input string name, input logic [31:0] exp, input int lat);
        int n = 1;
        int busy = 0;
        while (!out_valid && n < 200) begin
            if (in_ready) busy++;
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, lat);
        chk({name, "_result"}, result, exp);
        chk({name, "_in_ready_busy"}, busy, 0);
        if (out_ready) begin
            @(negedge clk);
            chk({name, "_out_valid_drop"}, out_valid, 0);
            chk({name, "_in_ready_back"}, in_ready, 1);
        end
    endtask

    vec_t vecs[12];

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb, rexp;
        int n;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,          32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; op = '0; reg1 = '0; reg2 = '0;
        in_valid8 = 1'b0; op8 = '0; reg1_8 = '0; reg2_8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst8_in_ready", in_ready8, 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result($sformatf("vec%0d", i), vecs[i].exp, is_special(vecs[i].op, vecs[i].a, vecs[i].b) ? 1 : 33);
        end

        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            rexp = model(ro, ra, rb);
            issue(ro, ra, rb);
            wait_result($sformatf("rnd%0d_op%0d", i, ro), rexp, is_special(ro, ra, rb) ? 1 : 33);
        end

        // Backpressure in DONE while a new request waits on the inputs
        out_ready = 1'b0;
        issue(3'd0, 32'd3, 32'd5);
        wait_result("bp_first", 32'd15, 33);
        op = 3'd5; reg1 = 32'd100; reg2 = 32'd7; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_out_valid", out_valid, 1);
            chk("bp_hold_result", result, 15);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_return", in_ready, 1);
        @(negedge clk);
        chk("bp_accepted", in_ready, 0);
        in_valid = 1'b0;
        wait_result("bp_next", 32'd14, 33);

        // Reset during CALC at iteration 10
        issue(3'd5, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        issue(3'd0, 32'd3, 32'd4);
        wait_result("post_rst_mul", 32'd12, 33);

        // XLEN=8 instance
        op8 = 3'd5; reg1_8 = 8'd200; reg2_8 = 8'd3; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0; reg1_8 = 8'($urandom); reg2_8 = 8'($urandom);
        n = 1;
        while (!out_valid8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("x8_divu_latency", n, 9);
        chk("x8_divu_result", result8, 66);
        @(negedge clk);
        chk("x8_in_ready_back", in_ready8, 1);
        op8 = 3'd1; reg1_8 = 8'h80; reg2_8 = 8'h80; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("x8_mulh_latency", n, 9);
        chk("x8_mulh_result", result8, 8'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
